// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types and defaults for the branch trace player
package branch_pkg;

    localparam int BRANCH_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [BRANCH_W_DEF-1:0] branch;
        logic                    taken;
    } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - single-write, asynchronous-read trace storage array
module trace_ram
    import branch_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int DATA_W = BRANCH_W_DEF + 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Contents carry no reset; only entries below trace_len are ever read as valid.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/branch_trace_player.sv
// rtl/branch_trace_player.sv - replays a loaded branch trace on a valid/ready stream
module branch_trace_player
    import branch_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int BRANCH_W = BRANCH_W_DEF,
    parameter int CNT_W    = 32,
    localparam int AW      = $clog2(DEPTH),
    localparam int LEN_W   = AW + 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_wr_en,
    input  logic [BRANCH_W-1:0] i_wr_branch,
    input  logic                i_wr_taken,
    input  logic                i_clear,
    input  logic                i_start,
    input  logic                i_loop,
    input  logic                i_stop,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [BRANCH_W-1:0] o_out_branch,
    output logic                o_out_taken,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_overflow,
    output logic [LEN_W-1:0]    o_trace_len,
    output logic [CNT_W-1:0]    o_issued,
    output logic [CNT_W-1:0]    o_passes
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [AW-1:0]      r_ptr;
    logic [LEN_W-1:0]   r_trace_len;
    logic               r_loop;
    logic               r_overflow;
    logic [CNT_W-1:0]   r_issued;
    logic [CNT_W-1:0]   r_passes;

    logic               w_in_idle;
    logic               w_in_play;
    logic               w_in_done;
    logic               w_full;
    logic               w_last;
    logic               w_xfer;
    logic               w_clear_ok;
    logic               w_start_ok;
    logic               w_wr_req;
    logic               w_wr_ok;
    logic               w_wr_drop;
    logic [BRANCH_W:0]  w_rdata;

    assign w_in_idle  = (r_state == ST_IDLE);
    assign w_in_play  = (r_state == ST_PLAY);
    assign w_in_done  = (r_state == ST_DONE);
    assign w_full     = (r_trace_len == LEN_W'(DEPTH));
    assign w_last     = ({1'b0, r_ptr} == (r_trace_len - LEN_W'(1)));
    assign w_xfer     = w_in_play & i_out_ready;

    // Priority in IDLE: clear, then start (needs a non-empty trace), then write.
    assign w_clear_ok = i_clear & (w_in_idle | w_in_done);
    assign w_start_ok = w_in_idle & i_start & ~i_clear & (r_trace_len != '0);
    assign w_wr_req   = w_in_idle & i_wr_en & ~i_clear & ~w_start_ok;
    assign w_wr_ok    = w_wr_req & ~w_full;
    assign w_wr_drop  = w_wr_req & w_full;

    trace_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (BRANCH_W + 1)
    ) u_trace_ram (
        .i_clk   (i_clk),
        .i_we    (w_wr_ok),
        .i_waddr (r_trace_len[AW-1:0]),
        .i_wdata ({i_wr_branch, i_wr_taken}),
        .i_raddr (r_ptr),
        .o_rdata (w_rdata)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection; stop beats a same-cycle final transfer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (i_stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_xfer && w_last && !r_loop) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_clear_ok) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Trace length, overflow flag, replay pointer and event/pass counters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_trace_len <= '0;
            r_overflow  <= 1'b0;
            r_ptr       <= '0;
            r_loop      <= 1'b0;
            r_issued    <= '0;
            r_passes    <= '0;
        end else begin
            if (w_clear_ok) begin
                r_trace_len <= '0;
                r_overflow  <= 1'b0;
            end else if (w_wr_ok) begin
                r_trace_len <= r_trace_len + LEN_W'(1);
            end else if (w_wr_drop) begin
                r_overflow  <= 1'b1;
            end

            if (w_start_ok) begin
                r_ptr    <= '0;
                r_loop   <= i_loop;
                r_issued <= '0;
                r_passes <= '0;
            end else if (w_xfer) begin
                r_issued <= r_issued + CNT_W'(1);
                if (w_last) begin
                    r_ptr    <= '0;
                    r_passes <= r_passes + CNT_W'(1);
                end else begin
                    r_ptr    <= r_ptr + AW'(1);
                end
            end
        end
    end

    assign o_out_valid  = w_in_play;
    assign o_busy       = w_in_play;
    assign o_done       = w_in_done;
    assign o_out_branch = w_rdata[BRANCH_W:1];
    assign o_out_taken  = w_rdata[0];
    assign o_overflow   = r_overflow;
    assign o_trace_len  = r_trace_len;
    assign o_issued     = r_issued;
    assign o_passes     = r_passes;

endmodule

// File: tb/tb_branch_trace_player.sv
// tb/tb_branch_trace_player.sv - self-checking bench for branch_trace_player
module tb_branch_trace_player;
    import branch_pkg::*;

    localparam int DEPTH = 8;
    localparam int BW    = BRANCH_W_DEF;
    localparam int CW    = 32;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_DONE = 2;

    logic          clk;
    logic          i_reset;
    logic          i_wr_en;
    logic [BW-1:0] i_wr_branch;
    logic          i_wr_taken;
    logic          i_clear;
    logic          i_start;
    logic          i_loop;
    logic          i_stop;
    logic          o_out_valid;
    logic          i_out_ready;
    logic [BW-1:0] o_out_branch;
    logic          o_out_taken;
    logic          o_busy;
    logic          o_done;
    logic          o_overflow;
    logic [LW-1:0] o_trace_len;
    logic [CW-1:0] o_issued;
    logic [CW-1:0] o_passes;

    int n_checks = 0;
    int n_fail   = 0;

    trace_entry_t m_trace[$];
    int           m_state;
    int           m_idx;
    logic [CW-1:0] m_issued;
    logic [CW-1:0] m_passes;
    bit           m_ovf;
    bit           m_loop;

    branch_trace_player #(
        .DEPTH    (DEPTH),
        .BRANCH_W (BW),
        .CNT_W    (CW)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_wr_en      (i_wr_en),
        .i_wr_branch  (i_wr_branch),
        .i_wr_taken   (i_wr_taken),
        .i_clear      (i_clear),
        .i_start      (i_start),
        .i_loop       (i_loop),
        .i_stop       (i_stop),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_out_branch (o_out_branch),
        .o_out_taken  (o_out_taken),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_overflow   (o_overflow),
        .o_trace_len  (o_trace_len),
        .o_issued     (o_issued),
        .o_passes     (o_passes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: the trace is a queue, replay walks an index over it.
    task automatic model_step();
        if (i_reset) begin
            m_trace.delete();
            m_state  = M_IDLE;
            m_idx    = 0;
            m_issued = '0;
            m_passes = '0;
            m_ovf    = 0;
            m_loop   = 0;
        end else begin
            case (m_state)
                M_IDLE: begin
                    if (i_clear) begin
                        m_trace.delete();
                        m_ovf = 0;
                    end else if (i_start && m_trace.size() > 0) begin
                        m_state  = M_PLAY;
                        m_idx    = 0;
                        m_issued = '0;
                        m_passes = '0;
                        m_loop   = i_loop;
                    end else if (i_wr_en) begin
                        if (m_trace.size() < DEPTH)
                            m_trace.push_back('{branch: i_wr_branch, taken: i_wr_taken});
                        else
                            m_ovf = 1;
                    end
                end
                M_PLAY: begin
                    if (i_out_ready) begin
                        m_issued = m_issued + 1;
                        if (m_idx == m_trace.size() - 1) begin
                            m_passes = m_passes + 1;
                            m_idx    = 0;
                            if (!m_loop) m_state = M_DONE;
                        end else begin
                            m_idx = m_idx + 1;
                        end
                    end
                    if (i_stop) m_state = M_IDLE;
                end
                default: begin
                    if (i_clear) begin
                        m_trace.delete();
                        m_ovf   = 0;
                        m_state = M_IDLE;
                    end
                end
            endcase
        end
    endtask

    task automatic compare_all();
        bit v;
        v = (m_state == M_PLAY);
        check("out_valid", 64'(o_out_valid), 64'(v));
        check("busy", 64'(o_busy), 64'(v));
        check("done", 64'(o_done), 64'(m_state == M_DONE));
        check("overflow", 64'(o_overflow), 64'(m_ovf));
        check("trace_len", 64'(o_trace_len), 64'(m_trace.size()));
        check("issued", 64'(o_issued), 64'(m_issued));
        check("passes", 64'(o_passes), 64'(m_passes));
        if (v) begin
            check("out_branch", 64'(o_out_branch), 64'(m_trace[m_idx].branch));
            check("out_taken", 64'(o_out_taken), 64'(m_trace[m_idx].taken));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wr(input logic [BW-1:0] b, input logic t);
        i_wr_en     = 1'b1;
        i_wr_branch = b;
        i_wr_taken  = t;
        step();
        i_wr_en     = 1'b0;
    endtask

    task automatic do_clear();
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
    endtask

    int rdy_seq[5];
    int acc;

    initial begin
        i_reset = 1'b1; i_wr_en = 1'b0; i_wr_branch = '0; i_wr_taken = 1'b0;
        i_clear = 1'b0; i_start = 1'b0; i_loop = 1'b0; i_stop = 1'b0;
        i_out_ready = 1'b0;
        @(negedge clk);
        step();
        step();
        i_reset = 1'b0;
        check("reset out_valid", 64'(o_out_valid), 64'd0);
        check("reset trace_len", 64'(o_trace_len), 64'd0);
        check("reset issued", 64'(o_issued), 64'd0);

        // Single-pass replay of three entries with ready always high.
        wr(4'd2, 1'b1); wr(4'd5, 1'b0); wr(4'd2, 1'b1);
        i_loop = 1'b0; i_start = 1'b1; i_out_ready = 1'b1;
        step();
        i_start = 1'b0;
        check("t1 ev0 valid", 64'(o_out_valid), 64'd1);
        check("t1 ev0 branch", 64'(o_out_branch), 64'd2);
        check("t1 ev0 taken", 64'(o_out_taken), 64'd1);
        step();
        check("t1 ev1 branch", 64'(o_out_branch), 64'd5);
        check("t1 ev1 taken", 64'(o_out_taken), 64'd0);
        step();
        check("t1 ev2 branch", 64'(o_out_branch), 64'd2);
        check("t1 ev2 taken", 64'(o_out_taken), 64'd1);
        step();
        check("t1 end valid", 64'(o_out_valid), 64'd0);
        check("t1 end done", 64'(o_done), 64'd1);
        check("t1 end issued", 64'(o_issued), 64'd3);
        check("t1 end passes", 64'(o_passes), 64'd1);
        do_clear();
        check("t1 clear done", 64'(o_done), 64'd0);
        check("t1 clear len", 64'(o_trace_len), 64'd0);

        // Same trace under backpressure.
        wr(4'd2, 1'b1); wr(4'd5, 1'b0); wr(4'd2, 1'b1);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        rdy_seq = '{1, 0, 0, 1, 1};
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            i_out_ready = rdy_seq[k][0];
            step();
            acc += rdy_seq[k];
            check("t2 issued", 64'(o_issued), 64'(acc));
            if (k == 1 || k == 2) check("t2 hold branch", 64'(o_out_branch), 64'd5);
        end
        check("t2 done", 64'(o_done), 64'd1);
        do_clear();

        // Overflow at DEPTH and its clearing.
        for (int k = 0; k < DEPTH + 2; k++) wr(BW'($urandom), 1'($urandom));
        check("t3 len full", 64'(o_trace_len), 64'(DEPTH));
        check("t3 overflow", 64'(o_overflow), 64'd1);
        do_clear();
        check("t3 clr len", 64'(o_trace_len), 64'd0);
        check("t3 clr overflow", 64'(o_overflow), 64'd0);

        // Looped replay of two entries, then stop.
        wr(4'd3, 1'b1); wr(4'd9, 1'b0);
        i_loop = 1'b1; i_start = 1'b1; i_out_ready = 1'b1;
        step();
        i_start = 1'b0;
        repeat (7) step();
        i_out_ready = 1'b0; i_stop = 1'b1;
        step();
        i_stop = 1'b0;
        check("t4 valid", 64'(o_out_valid), 64'd0);
        check("t4 busy", 64'(o_busy), 64'd0);
        check("t4 len", 64'(o_trace_len), 64'd2);
        check("t4 issued", 64'(o_issued), 64'd7);
        check("t4 passes", 64'(o_passes), 64'd3);
        do_clear();

        // Reset in mid-replay, then start on an empty trace.
        for (int k = 0; k < 5; k++) wr(BW'(k + 1), 1'(k));
        i_loop = 1'b0; i_start = 1'b1; i_out_ready = 1'b1;
        step();
        i_start = 1'b0;
        step();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        check("t5 valid", 64'(o_out_valid), 64'd0);
        check("t5 busy", 64'(o_busy), 64'd0);
        check("t5 len", 64'(o_trace_len), 64'd0);
        check("t5 issued", 64'(o_issued), 64'd0);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (3) begin
            check("t5 empty start valid", 64'(o_out_valid), 64'd0);
            step();
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            i_reset     = ($urandom_range(0, 149) == 0);
            i_clear     = ($urandom_range(0, 19) == 0);
            i_start     = ($urandom_range(0, 7) == 0);
            i_stop      = ($urandom_range(0, 29) == 0);
            i_wr_en     = 1'($urandom);
            i_wr_branch = BW'($urandom);
            i_wr_taken  = 1'($urandom);
            i_loop      = 1'($urandom);
            i_out_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_trace_player.md
Name: branch_trace_player

Overview:
- Upstream stimulus stage for the 2-bit saturating branch predictor.
- Holds a loadable trace of branch events (branch number, actual outcome) in an internal buffer.
- Replays the trace one event per accepted cycle on a valid/ready interface that feeds the predictor's outcome and branch-number inputs.
- Supports single-pass or looped replay, abort, and sticky status.

Parameters:
- DEPTH, 64, number of trace entries; power of two, at least 2.
- BRANCH_W, 4, width of the branch-number field.
- CNT_W, 32, width of the issued-event and pass counters.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  append one trace entry; honoured only in IDLE.
- wr_branch  input  BRANCH_W  branch number of the appended entry.
- wr_taken  input  1  actual outcome of the appended entry (1 = taken).
- clear  input  1  empty the trace; honoured only in IDLE or DONE.
- start  input  1  begin replay; honoured only in IDLE.
- loop  input  1  sampled at start: 1 = wrap to entry 0 after the last entry.
- stop  input  1  abort replay; honoured only in PLAY.
- out_valid  output  1  an event is presented.
- out_ready  input  1  consumer accepts the event.
- out_branch  output  BRANCH_W  branch number of the presented event.
- out_taken  output  1  outcome of the presented event (drives the predictor's in).
- busy  output  1  high in PLAY.
- done  output  1  high in DONE.
- overflow  output  1  sticky: a write was dropped because the trace was full.
- trace_len  output  clog2(DEPTH)+1  number of valid entries.
- issued  output  CNT_W  events accepted since the last start.
- passes  output  CNT_W  completed full passes since the last start.

Behaviour:
- Reset (synchronous, on the clk edge where reset=1):
  - state=IDLE; trace_len, read pointer, issued, passes = 0.
  - out_valid, busy, done, overflow = 0.
  - Buffer contents are don't-care.
  - Reset overrides every other input in that cycle, including mid-replay.
- State IDLE:
  - wr_en with trace_len<DEPTH: write to entry trace_len; trace_len+1 next cycle.
  - wr_en with trace_len==DEPTH: data dropped; overflow=1 (sticky until clear or reset).
  - clear: trace_len=0, overflow=0. If clear and wr_en are asserted together, clear wins and the write is dropped.
  - start with trace_len>0: go to PLAY; pointer=0; issued=0; passes=0; latch loop. start has priority over a same-cycle wr_en (the write is dropped).
  - start with trace_len==0: ignored; stay IDLE.
- State PLAY:
  - busy=1; out_valid=1 from the cycle after start.
  - out_branch and out_taken reflect the entry at the pointer (combinational read of the registered pointer).
  - Outputs hold stable while out_valid=1 and out_ready=0.
  - Transfer = out_valid & out_ready. On transfer: issued+1 (wraps at 2^CNT_W).
  - Transfer of a non-last entry: pointer+1.
  - Transfer of the last entry (pointer==trace_len-1), loop latched 1: pointer=0; passes+1. Replay continues with no bubble.
  - Transfer of the last entry, loop latched 0: passes+1; go to DONE; out_valid=0 next cycle.
  - stop: go to IDLE next cycle; out_valid=0 next cycle; the trace is retained. If a transfer occurs in the same cycle, it still counts (issued+1).
  - wr_en and clear are ignored.
- State DONE:
  - done=1; out_valid=0.
  - clear: trace_len=0; go to IDLE.
  - start: ignored; return to IDLE only via clear or reset.
  - issued and passes hold their values.
- Single-entry trace with loop=1: the same entry is re-presented every accepted cycle; passes increments on every transfer.
- Latency: start to first out_valid is 1 cycle. Accepted event to next event is 0 cycles (one event per clk when out_ready stays high).

Decomposition:
- Shared package branch_pkg:
  - BRANCH_W default.
  - State encoding: IDLE=2'd0, PLAY=2'd1, DONE=2'd2.
  - trace-entry typedef {branch, taken}.
- One natural sub-module: trace_ram, a DEPTH x (BRANCH_W+1) single-write, asynchronous-read register array. All control stays in the top.

Test Plan:
- Write 3 entries (b2/T, b5/N, b2/T) with loop=0, start, out_ready=1 -> out_valid high for exactly 3 cycles presenting 2/1, 5/0, 2/1; then done=1, issued=3, passes=1.
- Same trace, out_ready toggling 1,0,0,1,1 -> outputs hold on ready-low cycles; 3 transfers total; issued=3 only after the third accepted cycle.
- DEPTH=4; write 6 entries -> trace_len=4, overflow=1. clear -> trace_len=0, overflow=0.
- loop=1 with 2 entries, run 7 accepted cycles, then stop -> issued=7, passes=3, next cycle state IDLE with out_valid=0 and trace_len=2.
- Assert reset at the second accepted event of a 5-entry replay -> next cycle out_valid=0, busy=0, trace_len=0, issued=0. Also: start with an empty trace -> stays IDLE, out_valid never rises.
